// File: rtl/vision_pkg.sv
// Shared types and defaults for the vision pipeline.
// Pixel type, default frame geometry and the 3x3 window bundle.
package vision_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef struct packed {
        pixel_t p_mm;
        pixel_t p_0m;
        pixel_t p_pm;
        pixel_t p_m0;
        pixel_t p_00;
        pixel_t p_p0;
        pixel_t p_mp;
        pixel_t p_0p;
        pixel_t p_pp;
    } window_t;

endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: one write port and one asynchronous read port.
// Both ports share the address; contents are never cleared.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int DW    = 8
) (
    input  logic                     clock,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Asynchronous read of the old value at the current column.
    assign rdata_o = mem_q[addr_i];

    // Write the incoming value on accept.
    always_ff @(posedge clock) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds a 3x3 neighbourhood per accepted raster pixel for the gradient core.
// Two line buffers supply rows r-2 and r-1; the window shifts left per accept.
module sobel_window_gen
    import vision_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [PIX_W-1:0] pixel_mm,
    output logic [PIX_W-1:0] pixel_0m,
    output logic [PIX_W-1:0] pixel_pm,
    output logic [PIX_W-1:0] pixel_m0,
    output logic [PIX_W-1:0] pixel_00,
    output logic [PIX_W-1:0] pixel_p0,
    output logic [PIX_W-1:0] pixel_mp,
    output logic [PIX_W-1:0] pixel_0p,
    output logic [PIX_W-1:0] pixel_pp,
    output logic             out_valid,
    output logic             on_edge,
    output logic             out_eof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, pos_c;
    logic [RW-1:0] row_q, row_d, pos_r;
    logic          accept;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic out_valid_q, on_edge_q, out_eof_q;
    logic on_edge_d, out_eof_d;

    // Reset wins over an accept in the same cycle.
    assign accept = in_valid & ~rst;
    // A start-of-frame pixel is always position (0,0).
    assign pos_c  = in_sof ? '0 : col_q;
    assign pos_r  = in_sof ? '0 : row_q;

    // Raster position of the pixel after the one being accepted.
    always_comb begin
        col_d = pos_c + CW'(1);
        row_d = pos_r;
        if (pos_c == COL_LAST) begin
            col_d = '0;
            row_d = (pos_r == ROW_LAST) ? '0 : pos_r + RW'(1);
        end
    end

    // Position counters advance only on accepted pixels.
    always_ff @(posedge clock) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    line_buffer #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb0 (
        .clock   (clock),
        .we_i    (accept),
        .addr_i  (pos_c),
        .wdata_i (in_pixel),
        .rdata_o (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb1 (
        .clock   (clock),
        .we_i    (accept),
        .addr_i  (pos_c),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Shift the window left and load the new right column (rows r-2..r).
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            win_d[j][0] = win_q[j][1];
            win_d[j][1] = win_q[j][2];
        end
        win_d[0][2] = lb1_rd;
        win_d[1][2] = lb0_rd;
        win_d[2][2] = in_pixel;
        on_edge_d = (pos_r < RW'(2)) || (pos_c < CW'(2));
        out_eof_d = (pos_r == ROW_LAST) && (pos_c == COL_LAST);
    end

    // Window and status registers; hold on stall.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int j = 0; j < 3; j++)
                for (int i = 0; i < 3; i++)
                    win_q[j][i] <= '0;
            out_valid_q <= 1'b0;
            on_edge_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                win_q     <= win_d;
                on_edge_q <= on_edge_d;
                out_eof_q <= out_eof_d;
            end
        end
    end

    assign pixel_mm  = win_q[0][0];
    assign pixel_0m  = win_q[0][1];
    assign pixel_pm  = win_q[0][2];
    assign pixel_m0  = win_q[1][0];
    assign pixel_00  = win_q[1][1];
    assign pixel_p0  = win_q[1][2];
    assign pixel_mp  = win_q[2][0];
    assign pixel_0p  = win_q[2][1];
    assign pixel_pp  = win_q[2][2];
    assign out_valid = out_valid_q;
    assign on_edge   = on_edge_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 frame.
// Reference keeps the frame image and derives each window from positions.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clock = 1'b0;
    logic       rst, in_valid, in_sof;
    logic [7:0] in_pixel;
    logic [7:0] pixel_mm, pixel_0m, pixel_pm;
    logic [7:0] pixel_m0, pixel_00, pixel_p0;
    logic [7:0] pixel_mp, pixel_0p, pixel_pp;
    logic       out_valid, on_edge, out_eof;

    sobel_window_gen #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .pixel_mm  (pixel_mm),
        .pixel_0m  (pixel_0m),
        .pixel_pm  (pixel_pm),
        .pixel_m0  (pixel_m0),
        .pixel_00  (pixel_00),
        .pixel_p0  (pixel_p0),
        .pixel_mp  (pixel_mp),
        .pixel_0p  (pixel_0p),
        .pixel_pp  (pixel_pp),
        .out_valid (out_valid),
        .on_edge   (on_edge),
        .out_eof   (out_eof)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: current frame image and next raster position.
    logic [7:0] img [H][W];
    int         mr = 0;
    int         mc = 0;
    logic [7:0] etap [9];
    bit         eknown [9] = '{default: 1'b0};
    bit         ev, eedge, eeof, emeta = 1'b0;

    task automatic check(string tag, int obs, int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tap_obs(int k);
        case (k)
            0: return pixel_mm;
            1: return pixel_0m;
            2: return pixel_pm;
            3: return pixel_m0;
            4: return pixel_00;
            5: return pixel_p0;
            6: return pixel_mp;
            7: return pixel_0p;
            default: return pixel_pp;
        endcase
    endfunction

    task automatic step(bit r, bit v, bit s, logic [7:0] p);
        int rr, cc;
        @(negedge clock);
        rst = r; in_valid = v; in_sof = s; in_pixel = p;
        if (r) begin
            mr = 0; mc = 0;
            ev = 0; eedge = 0; eeof = 0; emeta = 1;
            for (int k = 0; k < 9; k++) begin
                etap[k] = 8'h00; eknown[k] = 1'b1;
            end
        end else if (v) begin
            if (s) begin mr = 0; mc = 0; end
            img[mr][mc] = p;
            ev = 1; emeta = 1;
            eedge = (mr <= 1) || (mc <= 1);
            eeof  = (mr == H - 1) && (mc == W - 1);
            for (int j = 0; j < 3; j++)
                for (int i = 0; i < 3; i++) begin
                    rr = mr - 2 + j;
                    cc = mc - 2 + i;
                    eknown[j*3+i] = (rr >= 0) && (cc >= 0);
                    etap[j*3+i] = eknown[j*3+i] ? img[rr][cc] : 8'h00;
                end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end else begin
            ev = 0; emeta = 0;
        end
        @(posedge clock);
        #1;
        check("out_valid", int'(out_valid), int'(ev));
        if (emeta) begin
            check("on_edge", int'(on_edge), int'(eedge));
            check("out_eof", int'(out_eof), int'(eeof));
        end
        for (int k = 0; k < 9; k++)
            if (eknown[k])
                check($sformatf("tap%0d", k), int'(tap_obs(k)), int'(etap[k]));
    endtask

    task automatic pixels(int n, bit sof_first, int stall_at, int nstall);
        int r0, c0;
        for (int n0 = 0; n0 < n; n0++) begin
            r0 = (n0 / W) % H;
            c0 = n0 % W;
            step(0, 1, sof_first && n0 == 0, 8'(16 * r0 + c0));
            if (n0 == stall_at)
                for (int s0 = 0; s0 < nstall; s0++)
                    step(0, 0, 0, 8'hEE);
        end
    endtask

    int x;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'h00;
        // Reset, then a full frame whose first pixel has no sof.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 8'h00);
        pixels(W * H, 0, -1, 0);
        // Full frame with a 3-cycle stall after (2,1).
        pixels(W * H, 1, 2 * W + 1, 3);
        // Explicit (3,3) window from the stalled frame.
        check("eof_pp", int'(pixel_pp), 32'h33);
        check("eof_00", int'(pixel_00), 32'h22);
        check("eof_flag", int'(out_eof), 1);
        // Back-to-back next frame, cut short at (1,2), then mid-frame sof.
        pixels(W + 3, 1, -1, 0);
        pixels(W * H, 1, 2 * W + 2, 0);
        // Partial frame into row 2, reset held 3 cycles with in_valid high.
        pixels(2 * W + 2, 1, -1, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 8'hAB);
        pixels(W * H, 0, -1, 0);
        // Explicit centre window of a fresh frame at (2,2).
        pixels(2 * W + 3, 1, -1, 0);
        check("c22_mm", int'(pixel_mm), 32'h00);
        check("c22_00", int'(pixel_00), 32'h11);
        check("c22_pp", int'(pixel_pp), 32'h22);
        check("c22_edge", int'(on_edge), 0);
        // Randomized stream: stalls, resets, stray sof, random pixels.
        for (int k = 0; k < 800; k++) begin
            x = $urandom_range(99);
            if (x < 3)
                step(1, 1'($urandom_range(1)), 0, 8'($urandom));
            else if (x < 28)
                step(0, 0, 1'($urandom_range(1)), 8'($urandom));
            else
                step(0, 1,
                     (mr == 0 && mc == 0) || ($urandom_range(99) < 3),
                     8'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Upstream stage of the edge-detection core. Accepts a raster-order 8-bit pixel stream, buffers two previous lines, and emits one 3x3 neighbourhood per accepted pixel. Outputs are named and placed to drive the eight neighbour inputs and the `on_edge` input of the gradient core directly, together with a valid strobe and a frame-end marker.

## Interface
- `PIX_W`, 8: pixel width in bits.
- `IMG_W`, 640: pixels per line; must be at least 3.
- `IMG_H`, 480: lines per frame; must be at least 3.

Reset is `rst`, synchronous and active-high. The clock is `clock`.

- `clock`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_pixel`  in  PIX_W  incoming pixel.
- `in_valid`  in  1  `in_pixel` is accepted this cycle; there is no backpressure.
- `in_sof`  in  1  start of frame; qualified by `in_valid`.
- `pixel_mm`, `pixel_0m`, `pixel_pm`, `pixel_m0`, `pixel_00`, `pixel_p0`, `pixel_mp`, `pixel_0p`, `pixel_pp`  out  PIX_W each  window taps, named `pixel_<dx><dy>`.
- `out_valid`  out  1  window taps are valid this cycle; a one-cycle strobe.
- `on_edge`  out  1  window is centred on the frame border or contains invalid data.
- `out_eof`  out  1  this window belongs to the last pixel of the frame.

## Operation
- **Position counters:** `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1. Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after (IMG_H-1, IMG_W-1).
- **Position of an accepted pixel:** an accepted pixel with `in_sof`=1 is position (0,0) regardless of the counter state, even mid-frame. The counters then continue from (0,1).
- **Line buffers:** there are two, LB0 and LB1, each IMG_W x PIX_W, addressed by `col`.
  - Reads are asynchronous.
  - Writes happen on accept: LB0[col] <= `in_pixel` and LB1[col] <= LB0[col] (old value).
- **Window registers** form a 3x3 array that shifts one column left on each accept.
  - The new right column is {LB1[col], LB0[col], `in_pixel`}, which are rows r-2, r-1 and r.
- **Tap mapping:**
  - dx: m = column c-2, 0 = column c-1, p = column c.
  - dy: m = row r-2, 0 = row r-1, p = row r.
  - `pixel_pp` = pixel (r,c), `pixel_00` = (r-1,c-1) is the centre, and `pixel_mm` = (r-2,c-2).
- **Output image offset:** the output frame is spatially offset by (1,1). Window k is centred on input (r-1,c-1).
- **on_edge** = 1 when r<=1 or c<=1, where (r,c) is the position of the pixel that produced the window. It covers the top and left border plus the garbage windows produced at row or column wrap.
- **out_eof** = 1 when (r,c) = (IMG_H-1, IMG_W-1).
- **Stall:** with `in_valid`=0, nothing shifts, the counters hold, `out_valid`=0 and the taps hold their last values.
- **Arithmetic:** there is none on pixel data; values pass through unmodified. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.
- **Reset:**
  - Counters go to (0,0); all taps, `out_valid`, `on_edge` and `out_eof` go to 0.
  - Line buffer contents are not cleared; they are don't-care because of `on_edge`.
  - A mid-frame reset discards the frame. The next accepted pixel is (0,0).

## Timing
- **Latency:** 1 cycle. A pixel accepted at edge t produces taps, `out_valid`, `on_edge` and `out_eof` registered at edge t+1.
- **Throughput:** one window per clock with continuous `in_valid`.
- **Output count:** exactly one `out_valid` per accepted pixel, so IMG_W*IMG_H per frame.
- **Reset vs accept:** `rst` asserted in the same cycle as `in_valid` wins; the pixel is dropped.
- **Back-to-back frames** need no gap cycles. The first pixel of the next frame produces a window with `on_edge`=1.

## Structure
- **Shared package:** `vision_pkg` holds `pixel_t` (logic [PIX_W-1:0]), the default IMG_W and IMG_H constants, and `window_t`, a packed struct of the nine taps for future stages.
- **Sub-module:** `line_buffer`, with parameters DEPTH and DW, one write port and one asynchronous read port at the same address. It is instantiated twice.
- **Top level:** counters, window shift array and output registers.

## Test plan
Use IMG_W=4 and IMG_H=4. Pixel value = 16*r + c unless stated.

- **Reset:** hold `rst` 3 cycles mid-stream -> all taps 0x00, `out_valid`=0, `on_edge`=0, `out_eof`=0. The next accepted pixel with `in_sof`=0 is treated as (0,0).
- **Full frame:**
  - Accepting (2,2)=0x22 -> next cycle `out_valid`=1, `on_edge`=0, `pixel_mm`=0x00, `pixel_0m`=0x01, `pixel_pm`=0x02, `pixel_m0`=0x10, `pixel_00`=0x11, `pixel_p0`=0x12, `pixel_mp`=0x20, `pixel_0p`=0x21, `pixel_pp`=0x22.
  - Windows for (1,x) and (x,1) have `on_edge`=1.
- **Stall:** drop `in_valid` for 3 cycles after (2,1) -> `out_valid`=0 for 3 cycles and taps held. The window for (2,2) is identical to the no-stall case.
- **Frame end and wrap:**
  - Pixel (3,3)=0x33 -> `out_eof`=1 and `pixel_pp`=0x33, `pixel_00`=0x22.
  - The next frame's first pixel -> `on_edge`=1, `out_eof`=0.
- **Mid-frame sof:** assert `in_sof` on the pixel after (1,2) -> that pixel is (0,0). Continuing, the window at (2,2) of the new frame matches the full-frame values above.
- **Mid-frame reset:** `rst` during row 2 -> outputs cleared next cycle. A fresh frame then reproduces the full-frame results exactly.
